// File: rtl/filter_pkg.sv
// Shared types and helpers for the filter sample feeder.
package filter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PREFILL  = 3'd1,
      ST_RUN      = 3'd2,
      ST_UNDERRUN = 3'd3,
      ST_HALT     = 3'd4
   } feeder_state_t;

   localparam int DEF_SIG_WIDTH = 16;

   // Channel tag width; a single channel still needs a 1-bit tag.
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/feeder_skid_buf.sv
// Two-entry valid/ready buffer carrying {sample, ch}; the head stays put until popped.
module feeder_skid_buf
   import filter_pkg::*;
#(
   parameter int WIDTH = DEF_SIG_WIDTH + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [1:0]       occupancy
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;

   // Flush beats a simultaneous push so in-flight data is dropped on arrival.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign head_data  = mem[rd_ptr];
   assign head_valid = (count != 2'd0);
   assign occupancy  = count;

endmodule

// File: rtl/filter_sample_feeder.sv
// Drains a channel-interleaved sample FIFO into the FIR datapath with prefill gating,
// pipelined full-rate reads, underrun detection and optional auto-restart.
module filter_sample_feeder
   import filter_pkg::*;
#(
   parameter int SIG_WIDTH = DEF_SIG_WIDTH,
   parameter int NUM_CH    = 2,
   parameter int LVL_WIDTH = 10,
   parameter int CH_WIDTH  = ch_width(NUM_CH),
   parameter int CNT_WIDTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_enable,
   input  logic                 i_auto_restart,
   input  logic [LVL_WIDTH-1:0] i_prefill_lvl,
   input  logic                 i_clr_status,
   input  logic                 i_ff_empty,
   input  logic [LVL_WIDTH-1:0] i_ff_level,
   input  logic [SIG_WIDTH-1:0] i_ff_dataout,
   output logic                 o_fifo_rden,
   output logic [SIG_WIDTH-1:0] o_sample,
   output logic [CH_WIDTH-1:0]  o_sample_ch,
   output logic                 o_sample_valid,
   input  logic                 i_sample_ready,
   output logic                 o_running,
   output logic                 o_underrun,
   output logic [CNT_WIDTH-1:0] o_underrun_cnt
);

   localparam int                BUF_W   = SIG_WIDTH + CH_WIDTH;
   localparam logic [CH_WIDTH-1:0] LAST_CH = CH_WIDTH'(NUM_CH - 1);

   feeder_state_t       state;
   feeder_state_t       state_nxt;
   logic                inflight;
   logic [CH_WIDTH-1:0] inflight_ch;
   logic [CH_WIDTH-1:0] ch_cnt;
   logic                pop;
   logic                rden;
   logic                buf_valid;
   logic [1:0]          buf_occ;
   logic [2:0]          credits;
   logic [BUF_W-1:0]    buf_data;

   assign pop     = buf_valid & i_sample_ready;
   assign credits = {1'b0, buf_occ} + {2'b00, inflight};
   assign rden    = (state == ST_RUN) & ~i_ff_empty & ((credits - {2'b00, pop}) < 3'd2);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (!i_enable) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:     state_nxt = ST_PREFILL;
            ST_PREFILL:  if (i_ff_level >= i_prefill_lvl) state_nxt = ST_RUN;
            ST_RUN:      if (i_ff_empty && (buf_occ == 2'd0) && !inflight && i_sample_ready)
                            state_nxt = ST_UNDERRUN;
            ST_UNDERRUN: state_nxt = i_auto_restart ? ST_PREFILL : ST_HALT;
            ST_HALT:     state_nxt = ST_HALT;
            default:     state_nxt = ST_IDLE;
         endcase
      end
   end

   // A read issued while disabling is not tracked, so its data is never buffered.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         inflight    <= 1'b0;
         inflight_ch <= '0;
         ch_cnt      <= '0;
      end else begin
         inflight <= rden & i_enable;
         if (rden) begin
            inflight_ch <= ch_cnt;
         end
         if (!i_enable) begin
            ch_cnt <= '0;
         end else if (rden) begin
            ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + CH_WIDTH'(1);
         end
      end
   end

   // A clear coinciding with an underrun zeroes the count but leaves the flag set.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_underrun     <= 1'b0;
         o_underrun_cnt <= '0;
      end else if (state == ST_UNDERRUN) begin
         o_underrun <= 1'b1;
         if (i_clr_status) begin
            o_underrun_cnt <= '0;
         end else if (!(&o_underrun_cnt)) begin
            o_underrun_cnt <= o_underrun_cnt + CNT_WIDTH'(1);
         end
      end else if (i_clr_status) begin
         o_underrun     <= 1'b0;
         o_underrun_cnt <= '0;
      end
   end

   feeder_skid_buf #(
      .WIDTH (BUF_W)
   ) u_skid_buf (
      .clk        (i_clk),
      .rst        (i_rst),
      .flush      (~i_enable),
      .push       (inflight),
      .push_data  ({i_ff_dataout, inflight_ch}),
      .pop        (pop),
      .head_data  (buf_data),
      .head_valid (buf_valid),
      .occupancy  (buf_occ)
   );

   assign o_fifo_rden    = rden;
   assign o_sample       = buf_data[BUF_W-1:CH_WIDTH];
   assign o_sample_ch    = buf_data[CH_WIDTH-1:0];
   assign o_sample_valid = buf_valid;
   assign o_running      = (state == ST_RUN);

endmodule

// File: doc/filter_sample_feeder.md
Name: filter_sample_feeder

Overview:
- Parametrised successor to the filter input FIFO reader.
- Drains an external synchronous FIFO holding channel-interleaved samples: NUM_CH words per frame, channel 0 first.
- Delivers samples to the FIR datapath over a valid/ready stream, with a channel tag on each sample.
- Adds a programmable prefill threshold, full-throughput pipelined reads, underrun detection and counting, and auto-restart.

Parameters:
- SIG_WIDTH, 16, sample width in bits.
- NUM_CH, 2, number of interleaved channels; ≥1.
- LVL_WIDTH, 10, width of the FIFO fill-level input.
- CH_WIDTH, $clog2(NUM_CH) (minimum 1), width of the channel tag.
- CNT_WIDTH, 16, width of the underrun counter.

Ports:
- i_clk, in, 1, clock.
- i_rst, in, 1, asynchronous active-high reset.
- i_enable, in, 1, feeder enable; low returns the block to IDLE.
- i_auto_restart, in, 1, after an underrun, re-prefill automatically instead of halting.
- i_prefill_lvl, in, LVL_WIDTH, fill level required before streaming starts.
- i_clr_status, in, 1, clears the sticky underrun flag and the underrun counter.
- i_ff_empty, in, 1, FIFO empty.
- i_ff_level, in, LVL_WIDTH, FIFO fill level.
- i_ff_dataout, in, SIG_WIDTH, FIFO read data; valid 1 cycle after o_fifo_rden.
- o_fifo_rden, out, 1, FIFO read strobe.
- o_sample, out, SIG_WIDTH, sample to the filter.
- o_sample_ch, out, CH_WIDTH, channel index of o_sample.
- o_sample_valid, out, 1, sample valid.
- i_sample_ready, in, 1, filter accepts the sample.
- o_running, out, 1, state is RUN.
- o_underrun, out, 1, sticky underrun flag.
- o_underrun_cnt, out, CNT_WIDTH, saturating underrun count.

Behaviour:
- Reset: all outputs 0; state IDLE; channel counter 0; buffer empty; no read in flight.
- State machine:
  - IDLE → PREFILL when i_enable=1.
  - PREFILL → RUN when i_ff_level ≥ i_prefill_lvl (unsigned compare). i_prefill_lvl=0 means RUN is entered on the next cycle.
  - RUN → UNDERRUN when i_ff_empty=1, the 2-entry output buffer is empty, no read is in flight, and i_sample_ready=1.
  - UNDERRUN lasts 1 cycle:
    - o_underrun set to 1.
    - o_underrun_cnt incremented, saturating at all-ones.
    - Next state PREFILL if i_auto_restart=1, else HALT.
  - HALT → IDLE when i_enable=0.
  - Any state → IDLE when i_enable=0.
- Leaving for IDLE:
  - The buffer is flushed.
  - Data from a read already in flight is discarded on arrival.
  - The channel counter resets to 0.
- Read pipeline:
  - FIFO read latency is fixed at 1 cycle.
  - Credits = buffered entries + reads in flight, maximum 2.
  - o_fifo_rden = (state==RUN) & !i_ff_empty & (credits − pop < 2), where pop = o_sample_valid & i_sample_ready.
  - This sustains 1 sample/cycle under continuous ready.
  - First o_sample_valid appears 2 cycles after entering RUN: read issued in the RUN entry cycle, data registered on the next edge.
- Stream rules:
  - o_sample and o_sample_ch hold stable while o_sample_valid=1 and i_sample_ready=0.
  - Samples are presented in FIFO order; none dropped or duplicated.
  - Ready may toggle arbitrarily.
- Channel tag:
  - Assigned at read issue; increments mod NUM_CH per read.
  - Preserved across underrun and re-prefill so interleave alignment is kept.
  - Reset only via IDLE or i_rst.
- o_running is high exactly while state is RUN.
- Simultaneous UNDERRUN and i_clr_status: the clear wins for the counter; the flag ends set.
- Asynchronous i_rst mid-stream aborts immediately; the outputs return to their reset values.

Decomposition:
- Shared package filter_pkg:
  - State encoding (IDLE, PREFILL, RUN, UNDERRUN, HALT).
  - Default SIG_WIDTH.
  - A channel-width helper function.
- One sub-module: feeder_skid_buf.
  - 2-entry valid/ready buffer carrying {sample, ch}.
  - Flush input; occupancy output.
- The FSM, credit logic and status counters stay in the top level.

Test Plan:
- Prefill gating: prefill_lvl=8, NUM_CH=2, write 7 words → no rden, valid=0; write the 8th → o_running=1 next cycle, first sample valid 2 cycles later, ch=0.
- Throughput: FIFO holds 0x0001..0x0020, ready held 1 → 32 consecutive valid cycles, data in order, ch alternating 0,1.
- Backpressure: ready pattern 1,0,0,1 repeating → every word delivered once in order; data/ch stable during stalls; credits never exceed 2.
- Underrun with auto_restart=1: FIFO drains after 5 words (ch sequence 0,1,0,1,0) → o_underrun=1, cnt=1, state PREFILL; after refill, the next sample is tagged ch=1.
- Underrun with auto_restart=0: → HALT, no rden; i_enable low then high → PREFILL, ch=0; i_clr_status → flag=0, cnt=0.
- Reset/disable mid-stream: i_enable=0 with a read in flight → that data is discarded, valid=0 next cycle. Async i_rst pulsed between clock edges → all outputs zero immediately.
